uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver: 2-FF input synchroniser, mid-bit sampling FSM, configurable

---
 rtl/uart_rx_fifo.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling FSM and show-ahead RX FIFO with valid/ready.
// Defining UART_RX_PARITY_EN adds one parity bit (PARITY_ODD selects odd) after the data bits.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               uart_rx,
  output logic [DATA_BITS-1:0]               m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               frame_err,
  output logic                               parity_err,
  output logic                               overrun
);
  localparam int CPB    = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W  = $clog2(CPB);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]           settle_q;
  logic                 armed_q;
  logic                 start_edge;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frame_done;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, rd_next;
  logic [FCNT_W-1:0]    count_q, count_d;
  logic [DATA_BITS-1:0] m_data_q, head_d;
  logic                 full, pop, push, good_frame;
  logic                 frame_err_q, parity_err_q, overrun_q;

  // Starts are ignored until the line has been seen high after the synchroniser
  // has flushed its reset value, so a line held low out of reset never starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      settle_q  <= '0;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      settle_q  <= {settle_q[0], 1'b1};
      armed_q   <= armed_q | (settle_q[1] & rx_sync_q);
    end
  end

  assign start_edge = armed_q & rx_prev_q & ~rx_sync_q;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    stop_bad_d = stop_bad_q;
    par_bad_d  = par_bad_q;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (start_edge) begin
          state_d    = S_START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          stop_bad_d = 1'b0;
          par_bad_d  = 1'b0;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          par_bad_d = rx_sync_q ^ (^shreg_q) ^ (PARITY_ODD != 0);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = '0;
          stop_bad_d = stop_bad_q | ~rx_sync_q;
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_d = 1'b0;
            state_d    = S_IDLE;
            frame_done = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      stop_bad_q <= 1'b0;
      par_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      stop_bad_q <= stop_bad_d;
      par_bad_q  <= par_bad_d;
    end
  end

  assign full       = (count_q == FULL_CNT);
  assign pop        = m_valid & m_ready;
  assign good_frame = frame_done & ~stop_bad_d & ~par_bad_q;
  assign push       = good_frame & (~full | pop);
  assign rd_next    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Registered head: bypass the write data when the slot being written becomes the head.
  assign head_d = (push && (wr_ptr_q == rd_next)) ? shreg_q : mem_q[rd_next];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      m_data_q     <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q     <= rd_next;
      count_q      <= count_d;
      if (count_d != '0) m_data_q <= head_d;
      frame_err_q  <= frame_done & stop_bad_d;
      parity_err_q <= frame_done & ~stop_bad_d & par_bad_q;
      overrun_q    <= good_frame & full & ~pop;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus random frames on two receiver instances (8N1 depth 4, and 7-bit 2-stop),
// checked against a queue-based model of accepted bytes and expected error pulses.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b0, rdy_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       val_a, val_b, fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;
  logic [2:0] cnt_a, cnt_b;

  int n_chk = 0, n_fail = 0;
  int fe_a_n = 0, pe_a_n = 0, ov_a_n = 0, fe_b_n = 0, pe_b_n = 0, ov_b_n = 0;
  int exp_fe = 0, exp_pe = 0, exp_ov = 0, exp_fe_b = 0;
  logic [7:0] q[$];
  logic [6:0] qb[$];
  logic [7:0] last_a;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .uart_rx(rx_a), .m_data(data_a), .m_valid(val_a), .m_ready(rdy_a),
    .fifo_count(cnt_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

  uart_rx_fifo #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .STOP_BITS(2),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst), .uart_rx(rx_b), .m_data(data_b), .m_valid(val_b), .m_ready(rdy_b),
    .fifo_count(cnt_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

  // Pulse counters: one count per high cycle, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (fe_a === 1'b1) fe_a_n++;
    if (pe_a === 1'b1) pe_a_n++;
    if (ov_a === 1'b1) ov_a_n++;
    if (fe_b === 1'b1) fe_b_n++;
    if (pe_b === 1'b1) pe_b_n++;
    if (ov_b === 1'b1) ov_b_n++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx_b = v; else rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [8:0] d, input int nbits, input int nstop,
                      input bit bad_stop, input bit has_par, input logic par_bit);
    drive(sel, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive(sel, d[i], CPB);
    if (has_par) drive(sel, par_bit, CPB);
    for (int s = 0; s < nstop; s++) drive(sel, !(bad_stop && s == nstop - 1), CPB);
  endtask

  task automatic frame_a(input logic [7:0] d, input bit bad_stop, input bit bad_par);
    send(1'b0, {1'b0, d}, 8, 1, bad_stop, PAR_ON, (^d) ^ bad_par);
    if (bad_stop) begin
      exp_fe++;
      drive(1'b0, 1'b1, 2 * CPB);
    end else if (bad_par && PAR_ON) exp_pe++;
    else if (q.size() == DEPTH) exp_ov++;
    else q.push_back(d);
  endtask

  task automatic frame_b(input logic [6:0] d, input bit bad_stop);
    send(1'b1, {2'b0, d}, 7, 2, bad_stop, PAR_ON, ^d);
    if (bad_stop) begin
      exp_fe_b++;
      drive(1'b1, 1'b1, 2 * CPB);
    end else qb.push_back(d);
  endtask

  task automatic state_a(input string tag);
    check({tag, "_cnt"}, 32'(cnt_a), 32'(q.size()));
    check({tag, "_valid"}, 32'(val_a), 32'(q.size() != 0));
    if (q.size() != 0) check({tag, "_head"}, 32'(data_a), 32'(q[0]));
    check({tag, "_ferr"}, fe_a_n, exp_fe);
    check({tag, "_perr"}, pe_a_n, exp_pe);
    check({tag, "_ovr"}, ov_a_n, exp_ov);
  endtask

  task automatic pop_a(input string tag);
    check({tag, "_data"}, 32'(data_a), 32'(q[0]));
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    last_a = q.pop_front();
    check({tag, "_cnt"}, 32'(cnt_a), 32'(q.size()));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cnt", 32'(cnt_a), 0);
    check("rst_valid", 32'(val_a), 0);
    check("rst_data", 32'(data_a), 0);
    check("rst_flags", {29'd0, fe_a, pe_a, ov_a}, 0);
    repeat (4) @(negedge clk);

    frame_a(8'hA5, 1'b0, 1'b0);
    state_a("t1");
    pop_a("t1_pop");

    frame_a(8'h55, 1'b0, 1'b0);
    frame_a(8'h0F, 1'b0, 1'b0);
    frame_a(8'hF0, 1'b0, 1'b0);
    frame_a(8'h81, 1'b0, 1'b0);
    frame_a(8'h3C, 1'b0, 1'b0);
    state_a("t2_full");
    for (int i = 0; i < DEPTH; i++) pop_a($sformatf("t2_pop%0d", i));
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    check("t2_empty_pop_cnt", 32'(cnt_a), 0);
    check("t2_empty_hold", 32'(data_a), 32'(last_a));

    frame_a(8'h12, 1'b1, 1'b0);
    state_a("t3");

    drive(1'b0, 1'b0, 6);
    drive(1'b0, 1'b1, 2 * CPB);
    state_a("t4_glitch");
    frame_a(8'h34, 1'b0, 1'b0);
    state_a("t4");
    pop_a("t4_pop");

`ifdef UART_RX_PARITY_EN
    frame_a(8'h03, 1'b0, 1'b0);
    state_a("t5_good");
    frame_a(8'h03, 1'b0, 1'b1);
    state_a("t5_bad");
    pop_a("t5_pop");
`endif

    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      int npop;
      d = 8'($urandom);
      frame_a(d, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      state_a($sformatf("rnd%0d", i));
      npop = $urandom_range(0, q.size());
      for (int k = 0; k < npop; k++) pop_a($sformatf("rnd%0d_pop%0d", i, k));
    end

    // Reset in the middle of a frame with the line left low
    drive(1'b0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, CPB);
    rx_a = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    repeat (3 * CPB) @(negedge clk);
    check("t6_data", 32'(data_a), 0);
    state_a("t6_low");
    drive(1'b0, 1'b1, 2 * CPB);
    frame_a(8'h34, 1'b0, 1'b0);
    state_a("t6_after");

    frame_b(7'h5A, 1'b0);
    check("t6b_cnt", 32'(cnt_b), 32'(qb.size()));
    check("t6b_data", 32'(data_b), 32'(qb[0]));
    frame_b(7'h2B, 1'b1);
    check("t6b_ferr", fe_b_n, exp_fe_b);
    check("t6b_cnt2", 32'(cnt_b), 32'(qb.size()));
    check("t6b_pe_ov", pe_b_n + ov_b_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
